// File: rtl/wieg_pkg.sv
// Shared types and constants for the cradle rocking controller:
// FSM state encoding, the speed/amplitude table and default parameters.
package wieg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROBEER = 2'd1,
    HOUD    = 2'd2,
    ALARM   = 2'd3
  } toestand_t;

  typedef struct packed {
    logic [2:0] snelheid;
    logic [2:0] amplitude;
  } wiegCode_t;

  localparam int WINDOW_DEF  = 64;
  localparam int DREMPEL_DEF = 16;
  localparam int N_MODES_DEF = 8;

  // Rocking table, gentle to vigorous: {snelheid, amplitude} per mode index.
  function automatic wiegCode_t tabel(input logic [2:0] mode);
    wiegCode_t code;
    case (mode)
      3'd0:    code = '{snelheid: 3'd1, amplitude: 3'd1};
      3'd1:    code = '{snelheid: 3'd2, amplitude: 3'd1};
      3'd2:    code = '{snelheid: 3'd2, amplitude: 3'd2};
      3'd3:    code = '{snelheid: 3'd3, amplitude: 3'd2};
      3'd4:    code = '{snelheid: 3'd3, amplitude: 3'd3};
      3'd5:    code = '{snelheid: 3'd4, amplitude: 3'd3};
      3'd6:    code = '{snelheid: 3'd4, amplitude: 3'd4};
      default: code = '{snelheid: 3'd5, amplitude: 3'd4};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/wieg_regelaar_venster_teller.sv
// Evaluation-window bookkeeping: counts tick strobes and saturating stressLaag
// samples, and flags the window-end cycle together with its inclusive score.
module venster_teller #(
  parameter int WINDOW = 64
) (
  input  logic       clk,
  input  logic       r,
  input  logic       wis,
  input  logic       actief,
  input  logic       tick,
  input  logic       stressLaag,
  output logic       vensterEind,
  output logic [7:0] score
);

  localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [TW-1:0] tickCnt;
  logic [7:0]    stressCnt;

  assign vensterEind = actief && tick && (tickCnt == TW'(WINDOW - 1));

  // Score already includes this cycle's sample so the window-end cycle counts.
  assign score = (stressLaag && (stressCnt != 8'hFF)) ? stressCnt + 8'd1 : stressCnt;

  // NOTE: sequential state is assigned with <= only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!r || wis || vensterEind) begin
      tickCnt   <= '0;
      stressCnt <= '0;
    end else if (actief) begin
      if (tick) tickCnt <= tickCnt + TW'(1);
      stressCnt <= score;
    end
  end

endmodule

// File: rtl/wieg_regelaar.sv
// Rocking-strategy controller: scores the current mode per window, holds a
// passing mode, advances through the table on failure and alarms after N_MODES.
module wieg_regelaar
  import wieg_pkg::*;
#(
  parameter int WINDOW  = WINDOW_DEF,
  parameter int DREMPEL = DREMPEL_DEF,
  parameter int N_MODES = N_MODES_DEF
) (
  input  logic       clk,
  input  logic       r,
  input  logic       enable,
  input  logic       tick,
  input  logic       stressLaag,
  output logic       motorAan,
  output logic [2:0] snelheid,
  output logic [2:0] amplitude,
  output logic [2:0] modus,
  output logic       vast,
  output logic       alarm
);

  toestand_t  toestand, toestandNext;
  logic [2:0] modeNext;
  logic [3:0] failCnt, failNext;
  logic       vensterEind;
  logic [7:0] score;

  logic       motorNext, vastNext, alarmNext;
  wiegCode_t  codeNext;

  venster_teller #(.WINDOW(WINDOW)) uTeller (
    .clk        (clk),
    .r          (r),
    .wis        (!enable || (toestand == IDLE)),
    .actief     (enable && ((toestand == PROBEER) || (toestand == HOUD))),
    .tick       (tick),
    .stressLaag (stressLaag),
    .vensterEind(vensterEind),
    .score      (score)
  );

  // State, mode, fail counter and the registered outputs all move together.
  always_ff @(posedge clk) begin
    if (!r) begin
      toestand  <= IDLE;
      modus     <= '0;
      failCnt   <= '0;
      motorAan  <= 1'b0;
      snelheid  <= '0;
      amplitude <= '0;
      vast      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      toestand  <= toestandNext;
      modus     <= modeNext;
      failCnt   <= failNext;
      motorAan  <= motorNext;
      snelheid  <= codeNext.snelheid;
      amplitude <= codeNext.amplitude;
      vast      <= vastNext;
      alarm     <= alarmNext;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    toestandNext = toestand;
    modeNext     = modus;
    failNext     = failCnt;
    if (!enable) begin
      toestandNext = IDLE;
      modeNext     = '0;
      failNext     = '0;
    end else begin
      case (toestand)
        IDLE: begin
          toestandNext = PROBEER;
          modeNext     = '0;
          failNext     = '0;
        end
        PROBEER, HOUD: begin
          if (vensterEind) begin
            if (score >= 8'(DREMPEL)) begin
              toestandNext = HOUD;
              failNext     = '0;
            end else if ((failCnt + 4'd1) < 4'(N_MODES)) begin
              toestandNext = PROBEER;
              modeNext     = (modus == 3'(N_MODES - 1)) ? 3'd0 : modus + 3'd1;
              failNext     = failCnt + 4'd1;
            end else begin
              toestandNext = ALARM;
              modeNext     = '0;
              failNext     = failCnt + 4'd1;
            end
          end
        end
        default: ;  // ALARM latches until enable drops or reset
      endcase
    end
  end

  // Outputs decoded from the next state so they land in the same edge.
  always_comb begin
    motorNext = (toestandNext != IDLE);
    vastNext  = (toestandNext == HOUD);
    alarmNext = (toestandNext == ALARM);
    codeNext  = motorNext ? tabel(modeNext) : '0;
  end

endmodule
